// File: rtl/pcs_tx_encoder.sv
// 64b/66b PCS transmit encoder: classifies XGMII columns, runs the TX FSM, emits sync header + block; 1-cycle latency.
// Optional saturating error-block counter on o_err_count when TX_ENC_ERR_CNT_EN is defined.
module pcs_tx_encoder #(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic        i_txc,
  input  logic        i_reset,
  input  logic [63:0] i_txd,
  input  logic [7:0]  i_txctl,
  input  logic        i_tx_pause,
  output logic        o_tx_ready,
  output logic [1:0]  o_tx_header,
  output logic [63:0] o_tx_data
`ifdef TX_ENC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
`endif
);

  localparam logic [1:0]  SYNC_DATA = 2'b10;
  localparam logic [1:0]  SYNC_CTL  = 2'b01;
  localparam logic [7:0]  RS_IDLE = 8'h07, RS_LPI = 8'h06, RS_START = 8'hFB, RS_TERM = 8'hFD;
  localparam logic [7:0]  RS_ERROR = 8'hFE, RS_OSEQ = 8'h9C, RS_OSIG = 8'h5C;
  localparam logic [7:0]  RS_RES0 = 8'h1C, RS_RES1 = 8'h3C, RS_RES2 = 8'h7C;
  localparam logic [7:0]  RS_RES3 = 8'hBC, RS_RES4 = 8'hDC, RS_RES5 = 8'hF7;
  localparam logic [6:0]  CC_IDLE = 7'h00, CC_LPI = 7'h06, CC_ERROR = 7'h1E;
  localparam logic [6:0]  CC_RES0 = 7'h2D, CC_RES1 = 7'h33, CC_RES2 = 7'h4B;
  localparam logic [6:0]  CC_RES3 = 7'h55, CC_RES4 = 7'h66, CC_RES5 = 7'h78;
  localparam logic [7:0]  BT_IDLE = 8'h1E, BT_O0 = 8'h4B, BT_S4 = 8'h33, BT_S0 = 8'h78;
  localparam logic [63:0] ERR_BLOCK  = 64'h3c78f1e3c78f1e1e;
  localparam logic [63:0] IDLE_BLOCK = 64'h1e;

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
  typedef enum logic [2:0] {CL_D, CL_C, CL_S, CL_O, CL_T, CL_E} col_class_e;

  function automatic logic rs_valid(input logic [7:0] b);
    case (b)
      RS_IDLE, RS_LPI, RS_ERROR, RS_RES0, RS_RES1,
      RS_RES2, RS_RES3, RS_RES4, RS_RES5: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] rs_to_cc(input logic [7:0] b);
    case (b)
      RS_IDLE: return CC_IDLE;
      RS_LPI:  return CC_LPI;
      RS_RES0: return CC_RES0;
      RS_RES1: return CC_RES1;
      RS_RES2: return CC_RES2;
      RS_RES3: return CC_RES3;
      RS_RES4: return CC_RES4;
      RS_RES5: return CC_RES5;
      default: return CC_ERROR;
    endcase
  endfunction

  function automatic logic [7:0] bt_term(input int n);
    case (n)
      0:       return 8'h87;
      1:       return 8'h99;
      2:       return 8'hAA;
      3:       return 8'hB4;
      4:       return 8'hCC;
      5:       return 8'hD2;
      6:       return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  tx_state_e   state_q, state_d;
  col_class_e  cls;
  logic [7:0]  lane [8];
  logic [6:0]  cc [8];
  logic [7:0]  ctl_ok;
  logic [1:0]  enc_hdr, hdr_d, hdr_q;
  logic [63:0] enc_dat, data_d, data_q;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane[k]   = i_txd[8*k +: 8];
      cc[k]     = rs_to_cc(lane[k]);
      ctl_ok[k] = rs_valid(lane[k]);
    end
  end

  // Every Tn layout places Ck at bit 8+7k, so the pad falls out of the defaults.
  always_comb begin
    cls     = CL_E;
    enc_hdr = SYNC_CTL;
    enc_dat = ERR_BLOCK;
    if (i_txctl == 8'h00) begin
      cls     = CL_D;
      enc_hdr = SYNC_DATA;
      enc_dat = i_txd;
    end else if (i_txctl == 8'hFF && &ctl_ok) begin
      cls     = CL_C;
      enc_dat = {cc[7], cc[6], cc[5], cc[4], cc[3], cc[2], cc[1], cc[0], BT_IDLE};
    end else if (i_txctl == 8'h01 && lane[0] == RS_START) begin
      cls     = CL_S;
      enc_dat = {i_txd[63:8], BT_S0};
    end else if (i_txctl == 8'h1F && lane[4] == RS_START && &ctl_ok[3:0]) begin
      cls     = CL_S;
      enc_dat = {i_txd[63:40], 4'h0, cc[3], cc[2], cc[1], cc[0], BT_S4};
    end else if (i_txctl == 8'hF1 && (lane[0] == RS_OSEQ || lane[0] == RS_OSIG) &&
                 i_txd[63:32] == {4{RS_IDLE}}) begin
      cls     = CL_O;
      enc_dat = {28'h0, (lane[0] == RS_OSIG) ? 4'hF : 4'h0, i_txd[31:8], BT_O0};
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (i_txctl == 8'(8'hFF << n) && lane[n] == RS_TERM &&
            &(ctl_ok | ~8'(8'hFE << n))) begin
          cls     = CL_T;
          enc_dat = {56'h0, bt_term(n)};
          for (int k = 0; k < 8; k++) begin
            if (k < n)      enc_dat[8+8*k +: 8] = lane[k];
            else if (k > n) enc_dat[8+7*k +: 7] = cc[k];
          end
        end
      end
    end
  end

  always_ff @(posedge i_txc) begin
    if (i_reset)          state_q <= TX_INIT;
    else if (!i_tx_pause) state_q <= state_d;
  end

  always_comb begin
    state_d = TX_E;
    case (state_q)
      TX_D: begin
        if (cls == CL_D)      state_d = TX_D;
        else if (cls == CL_T) state_d = TX_T;
      end
      TX_E: begin
        case (cls)
          CL_D, CL_S: state_d = TX_D;
          CL_T:       state_d = TX_T;
          CL_C, CL_O: state_d = TX_C;
          default:    state_d = TX_E;
        endcase
      end
      default: begin
        if (cls == CL_C || cls == CL_O) state_d = TX_C;
        else if (cls == CL_S)           state_d = TX_D;
      end
    endcase
  end

  always_comb begin
    hdr_d  = enc_hdr;
    data_d = enc_dat;
    if (state_d == TX_E) begin
      hdr_d  = SYNC_CTL;
      data_d = ERR_BLOCK;
    end
  end

  always_ff @(posedge i_txc) begin
    if (i_reset) begin
      hdr_q  <= SYNC_CTL;
      data_q <= IDLE_BLOCK;
    end else if (!i_tx_pause) begin
      hdr_q  <= hdr_d;
      data_q <= data_d;
    end
  end

  assign o_tx_ready  = ~i_tx_pause;
  assign o_tx_header = hdr_q;
  assign o_tx_data   = data_q;

`ifdef TX_ENC_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_d == TX_E && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_txc) begin
    if (i_reset)          err_cnt_q <= '0;
    else if (!i_tx_pause) err_cnt_q <= err_cnt_d;
  end

  assign o_err_count = err_cnt_q;
`else
  logic unused_err_cnt_cfg;
  assign unused_err_cnt_cfg = ^ERR_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Bench for pcs_tx_encoder: fixed vector table, hand-written pause/reset sequences, then random columns vs a block-level model.
module tb_pcs_tx_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] txd;
  logic [7:0]  ctl;
  logic        pause;
  logic        rdy;
  logic [1:0]  hdr;
  logic [63:0] dat;
`ifdef TX_ENC_ERR_CNT_EN
  logic [15:0] errc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pcs_tx_encoder #(.ERR_CNT_WIDTH(16)) dut (
    .i_txc       (clk),
    .i_reset     (rst),
    .i_txd       (txd),
    .i_txctl     (ctl),
    .i_tx_pause  (pause),
    .o_tx_ready  (rdy),
    .o_tx_header (hdr),
    .o_tx_data   (dat)
`ifdef TX_ENC_ERR_CNT_EN
    ,
    .o_err_count (errc)
`endif
  );

  localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
  localparam logic [63:0] ERRB     = 64'h3c78f1e3c78f1e1e;
  localparam logic [7:0]  RS_L [9] = '{8'h07, 8'h06, 8'hFE, 8'h1C, 8'h3C, 8'h7C, 8'hBC, 8'hDC, 8'hF7};
  localparam logic [6:0]  CC_L [9] = '{7'h00, 7'h06, 7'h1E, 7'h2D, 7'h33, 7'h4B, 7'h55, 7'h66, 7'h78};
  localparam logic [7:0]  BT_T [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  // Column classes D,C,S,O,T,E; states INIT,C,D,T,E. Row = state, column = class.
  localparam int NXT [5][6] = '{'{4, 1, 2, 1, 4, 4},
                               '{4, 1, 2, 1, 4, 4},
                               '{2, 4, 4, 4, 3, 4},
                               '{4, 1, 2, 1, 4, 4},
                               '{2, 1, 2, 1, 3, 4}};

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [1:0]  eh;
    logic [63:0] ed;
  } vec_t;
  vec_t tv [21];

  int          m_state;
  logic [1:0]  m_hdr;
  logic [63:0] m_dat;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [63:0] d, input logic [7:0] c, input logic p, input logic r);
    txd = d; ctl = c; pause = p; rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic int rs_idx(input logic [7:0] b);
    for (int i = 0; i < 9; i++) if (RS_L[i] == b) return i;
    return -1;
  endfunction

  function automatic void m_encode(input logic [63:0] d, input logic [7:0] c,
                                   output int cls, output logic [63:0] pay);
    logic [7:0] ln [8];
    logic [7:0] okm;
    int pos;
    bit tail_ok;
    cls = 5;
    pay = 64'h0;
    for (int k = 0; k < 8; k++) begin
      ln[k]  = d[8*k +: 8];
      okm[k] = (rs_idx(ln[k]) >= 0);
    end
    if (c == 8'h00) begin
      cls = 0; pay = d; return;
    end
    if (c == 8'hFF && okm == 8'hFF) begin
      pay = 64'h1E;
      for (int k = 0; k < 8; k++) pay |= 64'(CC_L[rs_idx(ln[k])]) << (8 + 7*k);
      cls = 1; return;
    end
    if (c == 8'h01 && ln[0] == 8'hFB) begin
      pay = {d[63:8], 8'h78}; cls = 2; return;
    end
    if (c == 8'h1F && ln[4] == 8'hFB && okm[3:0] == 4'hF) begin
      pay = 64'h33 | (d & 64'hFFFFFF0000000000);
      for (int k = 0; k < 4; k++) pay |= 64'(CC_L[rs_idx(ln[k])]) << (8 + 7*k);
      cls = 2; return;
    end
    if (c == 8'hF1 && (ln[0] == 8'h9C || ln[0] == 8'h5C) && d[63:32] == 32'h07070707) begin
      pay = 64'h4B | (d & 64'h00000000FFFFFF00) | ((ln[0] == 8'h5C ? 64'hF : 64'h0) << 32);
      cls = 3; return;
    end
    for (int n = 0; n < 8; n++) begin
      if (c == 8'(8'hFF << n) && ln[n] == 8'hFD) begin
        tail_ok = 1'b1;
        for (int k = n + 1; k < 8; k++) if (!okm[k]) tail_ok = 1'b0;
        if (tail_ok) begin
          pay = 64'(BT_T[n]);
          pos = 8;
          for (int k = 0; k < n; k++) begin pay |= 64'(ln[k]) << pos; pos += 8; end
          pos += 7 - n;
          for (int k = n + 1; k < 8; k++) begin pay |= 64'(CC_L[rs_idx(ln[k])]) << pos; pos += 7; end
          cls = 4;
        end
        return;
      end
    end
  endfunction

  task automatic m_step(input logic [63:0] d, input logic [7:0] c, input logic p, input logic r);
    int cls;
    logic [63:0] pay;
    if (r) begin
      m_state = 0; m_hdr = 2'b01; m_dat = 64'h1e; m_cnt = 0;
    end else if (!p) begin
      m_encode(d, c, cls, pay);
      m_state = NXT[m_state][cls];
      if (m_state == 4) begin
        m_hdr = 2'b01; m_dat = ERRB;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_hdr = (cls == 0) ? 2'b10 : 2'b01;
        m_dat = pay;
      end
    end
  endtask

  function automatic logic [7:0] rnd_ctl_byte();
    return RS_L[$urandom_range(0, 8)];
  endfunction

  task automatic gen_col(output logic [63:0] d, output logic [7:0] c);
    int kind, n;
    d = {$urandom, $urandom};
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1: begin
        c = 8'hFF;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = ($urandom_range(0, 3) == 0) ? rnd_ctl_byte() : 8'h07;
      end
      2: begin c = 8'h01; d[7:0] = 8'hFB; end
      3: begin
        c = 8'h1F; d[39:32] = 8'hFB;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = rnd_ctl_byte();
      end
      4, 5: c = 8'h00;
      6: begin
        n = $urandom_range(0, 7);
        c = 8'(8'hFF << n);
        d[8*n +: 8] = 8'hFD;
        for (int k = n + 1; k < 8; k++) d[8*k +: 8] = ($urandom_range(0, 1) == 0) ? 8'h07 : rnd_ctl_byte();
      end
      7: begin
        c = 8'hF1; d[63:32] = 32'h07070707;
        d[7:0] = ($urandom_range(0, 1) == 0) ? 8'h9C : 8'h5C;
      end
      default: c = 8'($urandom);
    endcase
    if ($urandom_range(0, 9) == 0) d[8*$urandom_range(0, 7) +: 8] = 8'($urandom);
  endtask

  initial begin
    logic [63:0] rd;
    logic [7:0]  rc;
    logic        rp, rr;

    tv[0]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[1]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[2]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[3]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[4]  = '{64'hd5555555555555fb,  8'h01, 2'b01, 64'hd555555555555578};
    tv[5]  = '{64'h0011223344556677,  8'h00, 2'b10, 64'h0011223344556677};
    tv[6]  = '{64'h07070707FDCCBBAA,  8'hF8, 2'b01, 64'h00000000CCBBAAB4};
    tv[7]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[8]  = '{64'h0123456789abcdef,  8'h00, 2'b01, ERRB};
    tv[9]  = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[10] = '{64'h070707070100009C,  8'hF1, 2'b01, 64'h000000000100004B};
    tv[11] = '{64'hFEFEFEFE0100009C,  8'hF1, 2'b01, ERRB};
    tv[12] = '{IDLE_COL,              8'hFF, 2'b01, 64'h1e};
    tv[13] = '{64'h332211FB07070707,  8'h1F, 2'b01, 64'h3322110000000033};
    tv[14] = '{64'h07070707070707FD,  8'hFF, 2'b01, 64'h0000000000000087};
    tv[15] = '{64'h07070707070707FE,  8'hFF, 2'b01, 64'h0000000000001E1E};
    tv[16] = '{64'h0123456789ABCDFB,  8'h01, 2'b01, 64'h0123456789ABCD78};
    tv[17] = '{64'hFD66554433221100,  8'h80, 2'b01, 64'h66554433221100FF};
    tv[18] = '{64'h55555555555555FB,  8'h01, 2'b01, 64'h5555555555555578};
    tv[19] = '{64'h55555555555555FB,  8'h01, 2'b01, ERRB};
    tv[20] = '{64'h0707FDEEDDCCBBAA,  8'hE0, 2'b01, 64'h0000EEDDCCBBAAD2};

    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    chk("reset_hdr", 64'(hdr), 64'h1);
    chk("reset_dat", dat, 64'h1e);
`ifdef TX_ENC_ERR_CNT_EN
    chk("reset_cnt", 64'(errc), 64'h0);
`endif
    for (int i = 0; i < 21; i++) begin
      cyc(tv[i].d, tv[i].c, 1'b0, 1'b0);
      chk($sformatf("vec%0d_hdr", i), 64'(hdr), 64'(tv[i].eh));
      chk($sformatf("vec%0d_dat", i), dat, tv[i].ed);
    end

    // Pause mid-frame with a new column presented; it must be taken only when pause drops.
    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b0);
    cyc(64'hd5555555555555fb, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(64'h0011223344556677, 8'h00, 1'b1, 1'b0);
      chk("pause_ready", 64'(rdy), 64'h0);
      chk("pause_hdr", 64'(hdr), 64'h1);
      chk("pause_dat", dat, 64'hd555555555555578);
    end
    cyc(64'h0011223344556677, 8'h00, 1'b0, 1'b0);
    chk("resume_ready", 64'(rdy), 64'h1);
    chk("resume_hdr", 64'(hdr), 64'h2);
    chk("resume_dat", dat, 64'h0011223344556677);
    cyc(64'h07070707FDCCBBAA, 8'hF8, 1'b0, 1'b0);
    chk("resume_term", dat, 64'h00000000CCBBAAB4);

    // Reset together with pause inside a frame: reset wins, FSM back at INIT.
    cyc(64'hd5555555555555fb, 8'h01, 1'b0, 1'b0);
    cyc(64'h1111111111111111, 8'h00, 1'b0, 1'b0);
    cyc(64'h2222222222222222, 8'h00, 1'b1, 1'b1);
    chk("rst_pause_hdr", 64'(hdr), 64'h1);
    chk("rst_pause_dat", dat, 64'h1e);
    cyc(64'h3333333333333333, 8'h00, 1'b0, 1'b0);
    chk("init_data_err", dat, ERRB);
    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b0);
    chk("recover_idle", dat, 64'h1e);

`ifdef TX_ENC_ERR_CNT_EN
    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(64'(i) * 64'h0101010101010101, 8'h5A, 1'b0, 1'b0);
    chk("errcnt_5", 64'(errc), 64'h5);
    cyc(IDLE_COL, 8'h5A, 1'b1, 1'b0);
    chk("errcnt_pause", 64'(errc), 64'h5);
    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    chk("errcnt_clr", 64'(errc), 64'h0);
`endif

    cyc(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    m_step(IDLE_COL, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      gen_col(rd, rc);
      rp = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 99) == 0);
      m_step(rd, rc, rp, rr);
      cyc(rd, rc, rp, rr);
      chk($sformatf("rnd%0d_ready", i), 64'(rdy), 64'(!rp));
      chk($sformatf("rnd%0d_hdr", i), 64'(hdr), 64'(m_hdr));
      chk($sformatf("rnd%0d_dat", i), dat, m_dat);
`ifdef TX_ENC_ERR_CNT_EN
      chk($sformatf("rnd%0d_cnt", i), 64'(errc), 64'(m_cnt));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
